// File: rtl/mesi_multi_ctrl.sv
// Multi-cache MESI coherence controller.
// Holds the MESI state of NUM_CORES private caches x NUM_LINES lines and serves
// one core request at a time: round-robin arbitration in IDLE, a one-cycle
// snoop that works out the outcome, then a one-cycle response that presents
// the bus/memory messages and commits every affected line state.
module mesi_multi_ctrl #(
    parameter int NUM_CORES = 4,
    parameter int NUM_LINES = 4,
    parameter int CORE_W    = $clog2(NUM_CORES),
    parameter int LINE_W    = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1
) (
    input  logic                        clock,
    input  logic                        resetn,
    input  logic [NUM_CORES-1:0]        req_valid,
    input  logic [NUM_CORES-1:0]        req_write,
    input  logic [NUM_CORES*LINE_W-1:0] req_line,
    output logic [CORE_W-1:0]           grant_core,
    output logic                        busy,
    output logic                        done,
    output logic [1:0]                  bus_out,
    output logic [1:0]                  mem_out,
    input  logic [CORE_W-1:0]           dbg_core,
    input  logic [LINE_W-1:0]           dbg_line,
    output logic [1:0]                  dbg_state
);

    localparam logic [1:0] ST_I = 2'd0;
    localparam logic [1:0] ST_S = 2'd1;
    localparam logic [1:0] ST_E = 2'd2;
    localparam logic [1:0] ST_M = 2'd3;

    localparam logic [1:0] BUS_NONE = 2'd0;
    localparam logic [1:0] BUS_RD   = 2'd1;
    localparam logic [1:0] BUS_RDX  = 2'd2;
    localparam logic [1:0] BUS_UPGR = 2'd3;

    localparam logic [1:0] MEM_NONE = 2'd0;
    localparam logic [1:0] MEM_RD   = 2'd1;
    localparam logic [1:0] MEM_WB   = 2'd2;

    typedef enum logic [1:0] {FSM_IDLE, FSM_SNOOP, FSM_RESP} fsm_t;
    // What happens to the copies held by the non-requesting caches.
    typedef enum logic [1:0] {OTH_KEEP, OTH_TO_S, OTH_TO_I} oth_t;

    fsm_t                fsm_reg, fsm_next;
    logic [CORE_W-1:0]   ptr_reg;
    logic [CORE_W-1:0]   core_reg;
    logic                write_reg;
    logic [LINE_W-1:0]   line_reg;
    logic [1:0]          bus_reg, mem_reg, req_new_reg;
    oth_t                oth_reg;

    logic [CORE_W-1:0]   cand, pick;
    logic                pick_valid;
    logic [1:0]          req_state;
    logic                other_m, other_v;
    logic [1:0]          bus_calc, mem_calc, req_new_calc;
    oth_t                oth_calc;
    logic                commit;

    logic [NUM_CORES-1:0][NUM_LINES-1:0][1:0] line_state;

    // Round-robin pick: first requesting core searching upward from ptr_reg+1.
    always_comb begin
        cand       = '0;
        pick       = '0;
        pick_valid = 1'b0;
        for (int i = 1; i <= NUM_CORES; i++) begin
            cand = CORE_W'((int'(ptr_reg) + i) % NUM_CORES);
            if (!pick_valid && req_valid[cand]) begin
                pick_valid = 1'b1;
                pick       = cand;
            end
        end
    end

    // Snoop the other caches and derive the transaction outcome.
    always_comb begin
        req_state    = line_state[core_reg][line_reg];
        other_m      = 1'b0;
        other_v      = 1'b0;
        for (int c = 0; c < NUM_CORES; c++) begin
            if (CORE_W'(c) != core_reg) begin
                if (line_state[CORE_W'(c)][line_reg] == ST_M) other_m = 1'b1;
                if (line_state[CORE_W'(c)][line_reg] != ST_I) other_v = 1'b1;
            end
        end
        bus_calc     = BUS_NONE;
        mem_calc     = MEM_NONE;
        req_new_calc = req_state;
        oth_calc     = OTH_KEEP;
        if (!write_reg) begin
            if (req_state == ST_I) begin
                bus_calc     = BUS_RD;
                mem_calc     = other_m ? MEM_WB : MEM_RD;
                req_new_calc = other_v ? ST_S : ST_E;
                oth_calc     = other_v ? OTH_TO_S : OTH_KEEP;
            end
        end else begin
            case (req_state)
                ST_M: ;
                ST_E: req_new_calc = ST_M;
                ST_S: begin
                    bus_calc     = BUS_UPGR;
                    req_new_calc = ST_M;
                    oth_calc     = OTH_TO_I;
                end
                default: begin
                    bus_calc     = BUS_RDX;
                    mem_calc     = other_m ? MEM_WB : MEM_RD;
                    req_new_calc = ST_M;
                    oth_calc     = OTH_TO_I;
                end
            endcase
        end
    end

    // Next-state logic of the transaction sequencer.
    always_comb begin
        fsm_next = fsm_reg;
        case (fsm_reg)
            FSM_IDLE:  if (pick_valid) fsm_next = FSM_SNOOP;
            FSM_SNOOP: fsm_next = FSM_RESP;
            FSM_RESP:  fsm_next = FSM_IDLE;
            default:   fsm_next = FSM_IDLE;
        endcase
    end

    // Sequencer state, latched request and registered response messages.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            fsm_reg     <= FSM_IDLE;
            ptr_reg     <= CORE_W'(NUM_CORES - 1);
            core_reg    <= '0;
            write_reg   <= 1'b0;
            line_reg    <= '0;
            bus_reg     <= BUS_NONE;
            mem_reg     <= MEM_NONE;
            req_new_reg <= ST_I;
            oth_reg     <= OTH_KEEP;
        end else begin
            fsm_reg <= fsm_next;
            bus_reg <= BUS_NONE;
            mem_reg <= MEM_NONE;
            if (fsm_reg == FSM_IDLE && pick_valid) begin
                core_reg  <= pick;
                ptr_reg   <= pick;
                write_reg <= req_write[pick];
                line_reg  <= req_line[int'(pick)*LINE_W +: LINE_W];
            end
            if (fsm_reg == FSM_SNOOP) begin
                bus_reg     <= bus_calc;
                mem_reg     <= mem_calc;
                req_new_reg <= req_new_calc;
                oth_reg     <= oth_calc;
            end
        end
    end

    assign commit = (fsm_reg == FSM_RESP);

    // One state row per cache; all rows update together at the end of RESP.
    for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_core
        logic [NUM_LINES-1:0][1:0] row_reg;

        // Commit the requester's new state and the snoop effect on this cache.
        always_ff @(posedge clock) begin
            if (!resetn) begin
                row_reg <= '0;
            end else if (commit) begin
                if (core_reg == CORE_W'(gi)) begin
                    row_reg[line_reg] <= req_new_reg;
                end else if (oth_reg == OTH_TO_I) begin
                    row_reg[line_reg] <= ST_I;
                end else if (oth_reg == OTH_TO_S && row_reg[line_reg] != ST_I) begin
                    row_reg[line_reg] <= ST_S;
                end
            end
        end

        assign line_state[gi] = row_reg;
    end

    assign grant_core = core_reg;
    assign busy       = (fsm_reg != FSM_IDLE);
    assign done       = (fsm_reg == FSM_RESP);
    assign bus_out    = bus_reg;
    assign mem_out    = mem_reg;
    assign dbg_state  = line_state[dbg_core][dbg_line];

endmodule

// File: tb/tb_mesi_multi_ctrl.sv
// Bench for mesi_multi_ctrl: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a transaction-level model.
module tb_mesi_multi_ctrl;

    localparam int NC   = 8;
    localparam int NL   = 16;
    localparam int CW   = 3;
    localparam int LW   = 4;
    localparam int HALF = 200;

    logic              clock = 1'b0;
    logic              resetn = 1'b1;
    logic [NC-1:0]     req_valid = '0;
    logic [NC-1:0]     req_write = '0;
    logic [NC*LW-1:0]  req_line = '0;
    logic [CW-1:0]     grant_core;
    logic              busy, done;
    logic [1:0]        bus_out, mem_out;
    logic [CW-1:0]     dbg_core = '0;
    logic [LW-1:0]     dbg_line = '0;
    logic [1:0]        dbg_state;

    int checks = 0;
    int errors = 0;

    mesi_multi_ctrl #(.NUM_CORES(NC), .NUM_LINES(NL)) dut (
        .clock(clock), .resetn(resetn),
        .req_valid(req_valid), .req_write(req_write), .req_line(req_line),
        .grant_core(grant_core), .busy(busy), .done(done),
        .bus_out(bus_out), .mem_out(mem_out),
        .dbg_core(dbg_core), .dbg_line(dbg_line), .dbg_state(dbg_state)
    );

    always #HALF clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    int ms [NC][NL];      // MESI state per cache/line (0 I,1 S,2 E,3 M)
    int pend [NC];        // states of the served line after the transaction
    int m_phase = 0;      // cycles into the current transaction (0 = idle)
    int m_last = NC - 1;
    int m_grant = 0;
    int m_line = 0;
    int m_bus = 0;
    int m_mem = 0;
    int m_commits = 0;
    bit m_init = 1'b0;
    bit m_committed = 1'b0;

    // Whole-transaction outcome: readers end up sharing, a writer ends up sole owner.
    task automatic model_txn(input int c, input bit w, input int l);
        int own;
        bit any_m, any_v;
        own = ms[c][l];
        any_m = 0;
        any_v = 0;
        for (int k = 0; k < NC; k++) begin
            pend[k] = ms[k][l];
            if (k != c && ms[k][l] == 3) any_m = 1;
            if (k != c && ms[k][l] != 0) any_v = 1;
        end
        m_bus = 0;
        m_mem = 0;
        if (!w) begin
            if (own == 0) begin
                m_bus = 1;
                m_mem = any_m ? 2 : 1;
                for (int k = 0; k < NC; k++) if (pend[k] != 0) pend[k] = 1;
                pend[c] = any_v ? 1 : 2;
            end
        end else begin
            if (own == 1) m_bus = 3;
            if (own == 0) begin
                m_bus = 2;
                m_mem = any_m ? 2 : 1;
            end
            for (int k = 0; k < NC; k++) pend[k] = 0;
            pend[c] = 3;
        end
    endtask

    always @(posedge clock) begin
        if (!resetn) begin
            for (int c = 0; c < NC; c++) for (int l = 0; l < NL; l++) ms[c][l] = 0;
            m_phase = 0;
            m_last = NC - 1;
            m_grant = 0;
            m_bus = 0;
            m_mem = 0;
            m_init = 1'b1;
        end else if (m_init) begin
            if (m_phase == 0) begin
                bit found;
                int k;
                found = 0;
                for (int i = 1; i <= NC; i++) begin
                    k = (m_last + i) % NC;
                    if (!found && req_valid[k]) begin
                        found = 1;
                        m_grant = k;
                    end
                end
                if (found) begin
                    m_last = m_grant;
                    m_line = int'(req_line[m_grant*LW +: LW]);
                    model_txn(m_grant, req_write[m_grant], m_line);
                    m_phase = 1;
                end
            end else if (m_phase == 1) begin
                m_phase = 2;
            end else begin
                for (int k = 0; k < NC; k++) ms[k][m_line] = pend[k];
                m_phase = 0;
                m_commits++;
                m_committed = 1'b1;
            end
        end
    end

    // Per-cycle comparison; after each commit sweep every entry and the ownership rule.
    always @(negedge clock) begin
        if (m_init) begin
            chk("busy", 32'(busy), 32'(m_phase != 0));
            chk("done", 32'(done), 32'(m_phase == 2));
            chk("grant_core", 32'(grant_core), 32'(m_grant));
            chk("bus_out", 32'(bus_out), (m_phase == 2) ? 32'(m_bus) : 32'd0);
            chk("mem_out", 32'(mem_out), (m_phase == 2) ? 32'(m_mem) : 32'd0);
            if (m_committed) begin
                m_committed = 1'b0;
                for (int l = 0; l < NL; l++) begin
                    int owners, holders;
                    owners = 0;
                    holders = 0;
                    for (int c = 0; c < NC; c++) begin
                        dbg_core = CW'(c);
                        dbg_line = LW'(l);
                        #1;
                        chk("state", 32'(dbg_state), 32'(ms[c][l]));
                        if (dbg_state >= 2) owners++;
                        if (dbg_state != 0) holders++;
                    end
                    chk("single_owner", 32'(owners == 0 || (owners == 1 && holders == 1)), 32'd1);
                end
            end
        end
    end

    // ---------------- directed helpers ----------------
    task automatic do_reset();
        @(posedge clock); #2;
        resetn = 1'b0;
        req_valid = '0;
        @(posedge clock);
        @(posedge clock); #2;
        resetn = 1'b1;
    endtask

    task automatic peek(input int c, input int l, input int exp, input string name);
        dbg_core = CW'(c);
        dbg_line = LW'(l);
        #1;
        chk(name, 32'(dbg_state), 32'(exp));
    endtask

    // One request from an idle controller; expects done two cycles after acceptance.
    task automatic txn(input int c, input bit w, input int l, input int eb, input int em);
        int n;
        @(posedge clock); #2;
        req_valid[c] = 1'b1;
        req_write[c] = w;
        req_line[c*LW +: LW] = LW'(l);
        n = 0;
        do begin
            @(posedge clock); #2;
            n++;
        end while (!done && n < 20);
        chk("txn_latency", 32'(n), 32'd2);
        chk("txn_grant", 32'(grant_core), 32'(c));
        chk("txn_bus", 32'(bus_out), 32'(eb));
        chk("txn_mem", 32'(mem_out), 32'(em));
        req_valid[c] = 1'b0;
        @(posedge clock); #3;
    endtask

    initial begin
        int g [5];
        int t [5];
        int nd, cyc, base;

        do_reset();

        // Read/write sharing sequence on line 2.
        txn(0, 1'b0, 2, 1, 1);
        peek(0, 2, 2, "dbg_c0_read_E");
        txn(1, 1'b0, 2, 1, 1);
        peek(0, 2, 1, "dbg_c0_shared");
        peek(1, 2, 1, "dbg_c1_shared");
        txn(0, 1'b1, 2, 3, 0);
        peek(0, 2, 3, "dbg_c0_upgr_M");
        peek(1, 2, 0, "dbg_c1_upgr_I");
        txn(1, 1'b1, 2, 2, 2);
        peek(0, 2, 0, "dbg_c0_rdx_I");
        peek(1, 2, 3, "dbg_c1_rdx_M");
        txn(1, 1'b0, 2, 0, 0);
        peek(1, 2, 3, "dbg_c1_hit_M");

        // Four cores requesting continuously after reset.
        do_reset();
        @(posedge clock); #2;
        for (int k = 0; k < 4; k++) begin
            req_write[k] = 1'b0;
            req_line[k*LW +: LW] = LW'(k + 4);
        end
        req_valid[3:0] = 4'hF;
        nd = 0;
        cyc = 0;
        while (nd < 5 && cyc < 60) begin
            @(posedge clock); #2;
            cyc++;
            if (done) begin
                g[nd] = int'(grant_core);
                t[nd] = cyc;
                nd++;
            end
        end
        req_valid = '0;
        chk("rr_done_count", 32'(nd), 32'd5);
        for (int i = 0; i < 5; i++) begin
            if (i < nd) begin
                chk("rr_grant", 32'(g[i]), 32'(i % 4));
                if (i > 0) chk("rr_spacing", 32'(t[i] - t[i-1]), 32'd3);
            end
        end

        // Reset while core 2's write of line 1 is in SNOOP.
        do_reset();
        @(posedge clock); #2;
        req_valid[2] = 1'b1;
        req_write[2] = 1'b1;
        req_line[2*LW +: LW] = LW'(1);
        @(posedge clock); #2;
        chk("mid_in_snoop", 32'(busy && !done), 32'd1);
        resetn = 1'b0;
        req_valid = '0;
        @(posedge clock); #2;
        chk("mid_done", 32'(done), 32'd0);
        chk("mid_busy", 32'(busy), 32'd0);
        chk("mid_bus", 32'(bus_out), 32'd0);
        chk("mid_mem", 32'(mem_out), 32'd0);
        resetn = 1'b1;
        nd = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clock); #2;
            if (done) nd++;
        end
        chk("mid_no_done", 32'(nd), 32'd0);
        for (int c = 0; c < 4; c++) peek(c, 1, 0, "mid_state_I");

        // Randomized stress: 2000 transactions with line reuse for heavy sharing.
        base = m_commits;
        cyc = 0;
        while (m_commits - base < 2000 && cyc < 20000) begin
            @(posedge clock); #2;
            cyc++;
            req_valid = NC'($urandom & $urandom);
            req_write = NC'($urandom);
            for (int k = 0; k < NC; k++)
                req_line[k*LW +: LW] = ($urandom_range(0, 1) == 0) ? LW'($urandom_range(0, 2))
                                                                  : LW'($urandom_range(0, NL - 1));
        end
        req_valid = '0;
        chk("stress_completed", 32'(m_commits - base >= 2000), 32'd1);
        repeat (4) @(posedge clock);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mesi_multi_ctrl.md
Name: mesi_multi_ctrl

Overview:
- Parametrised successor to the single-cache MESI state machine.
- Holds MESI state for NUM_CORES private caches × NUM_LINES lines.
- Arbitrates core requests round-robin, snoops the other caches, emits one 2-bit bus message and one 2-bit memory message per transaction, and updates every affected line state.
- Sits between the board-level switch/key decoding and the seven-segment display drivers; the debug read port feeds the state display.

Parameters:
- NUM_CORES, 4, number of caches; legal 2..8.
- NUM_LINES, 4, lines per cache; legal 1..16.
- CORE_W, $clog2(NUM_CORES), width of core index.
- LINE_W, max(1,$clog2(NUM_LINES)), width of line index.

Ports:
- clock  in  1  single clock; all state changes on the rising edge.
- resetn  in  1  synchronous, active-low reset.
- req_valid  in  NUM_CORES  per-core request pending.
- req_write  in  NUM_CORES  per-core op: 1 = write, 0 = read.
- req_line  in  NUM_CORES*LINE_W  per-core line index; core k uses bits [k*LINE_W +: LINE_W].
- grant_core  out  CORE_W  core currently being served.
- busy  out  1  transaction in progress (SNOOP or RESP).
- done  out  1  one-cycle pulse in RESP.
- bus_out  out  2  bus message: 0 none, 1 BusRd, 2 BusRdX, 3 BusUpgr.
- mem_out  out  2  memory message: 0 none, 1 Read, 2 WriteBack.
- dbg_core  in  CORE_W  debug read core select.
- dbg_line  in  LINE_W  debug read line select.
- dbg_state  out  2  combinational MESI state of (dbg_core, dbg_line).

Behaviour:
- State encoding: 0 I, 1 S, 2 E, 3 M.
- Reset (resetn = 0 at an edge):
  - all line states I; FSM to IDLE.
  - grant_core 0, busy 0, done 0, bus_out 0, mem_out 0.
  - round-robin pointer set so core 0 has highest priority.
- Reset mid-transaction aborts it. No line state update, no done pulse.
- FSM: IDLE -> SNOOP -> RESP -> IDLE.
- IDLE:
  - If any req_valid bit is set, grant the first set bit searching upward from (last_grant+1) mod NUM_CORES, wrapping.
  - Latch core, op and line; set grant_core; go to SNOOP.
  - Later changes on that core's request inputs are ignored until back in IDLE.
  - With no request, outputs hold bus_out = 0, mem_out = 0, done = 0.
- SNOOP (1 cycle), with busy = 1:
  - Compute other_M (any other core in M for the line) and other_V (any other core not in I).
  - Compute the next states and messages. No state change yet.
- RESP (1 cycle):
  - bus_out and mem_out are registered and valid only in this cycle; done = 1.
  - All line-state updates commit at the edge that ends RESP.
- Read, requester state S/E/M: bus 0, mem 0, no state change.
- Read, requester state I (bus 1):
  - other_M: mem 2 (writeback of the owner); owner M->S; requester S.
  - else other_V: mem 1; other E->S; requester S.
  - else: mem 1; requester E.
- Write, requester state M: bus 0, mem 0.
- Write, requester state E: bus 0, mem 0; requester -> M silently.
- Write, requester state S: bus 3, mem 0; all other copies -> I; requester M.
- Write, requester state I: bus 2.
  - mem 2 if other_M, else mem 1.
  - all other copies -> I; requester M.
- Latency and throughput: a request accepted at IDLE edge t has done at t+2 and returns to IDLE at t+3. Max throughput is one transaction per 3 cycles.
- Fairness: the requester must drop req_valid during done or it re-enters arbitration. The rotated pointer prevents starvation. Every requesting core is served within NUM_CORES transactions.
- Invariant, checked by the bench after every commit: per line, at most one core in M or E; if any core is in M or E, all others are I.
- dbg_state is purely combinational from the state array. A debug read during the commit edge returns the pre-commit value that cycle.

Test Plan:
- Reset, then core 0 reads line 2 -> bus 1, mem 1, done 2 cycles after grant, dbg(0,2) = E.
- Core 1 then reads line 2 -> bus 1, mem 1; dbg(0,2) = S, dbg(1,2) = S.
- Core 0 writes line 2 (state S) -> bus 3, mem 0; dbg(0,2) = M, dbg(1,2) = I.
  - Core 1 then writes line 2 -> bus 2, mem 2; dbg(0,2) = I, dbg(1,2) = M.
  - Core 1 then reads line 2 -> bus 0, mem 0, no change.
- All four cores assert req_valid continuously after reset -> grants 0,1,2,3,0 in order, each done spaced 3 cycles apart.
- resetn low during SNOOP of core 2 write line 1 -> no done; all dbg states I; bus_out/mem_out 0 next cycle.
- Random 2000-request stress, NUM_CORES = 8, NUM_LINES = 16 -> single-owner invariant never violated; states match the reference model every commit.
